// File: rtl/present_dec_control.sv
// Round sequencer for the PRESENT-80 decryption datapath: optional forward
// key-expansion pass, then 32 inverse rounds counting down, then a ready pulse.
module present_dec_control #(
  parameter bit KEY_PRE = 1'b1,
  parameter int CW      = 5
) (
  input  logic          ck,
  input  logic          rn,
  input  logic          sta,
  output logic [CW-1:0] cnt,
  output logic          kex,
  output logic          act,
  output logic          rf,
  output logic          k0,
  output logic          rdy,
  output logic          busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_KEY  = 2'd1,
    S_DEC  = 2'd2
  } state_t;

  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_rdy;
  logic          w_rdy_nxt;

  // State, counter and ready pulse registers
  always_ff @(posedge ck or negedge rn) begin
    if (!rn) begin
      r_state <= S_IDLE;
      r_cnt   <= CNT_ZERO;
      r_rdy   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rdy   <= w_rdy_nxt;
    end
  end

  // Next-state logic; a start request overrides whatever run is in progress
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rdy_nxt   = 1'b0;
    if (sta) begin
      if (KEY_PRE) begin
        w_state_nxt = S_KEY;
        w_cnt_nxt   = CNT_ZERO;
      end else begin
        w_state_nxt = S_DEC;
        w_cnt_nxt   = CNT_MAX;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = r_cnt;
        end
        S_KEY: begin
          // Key schedule ends on K32, which is exactly the first key decryption needs
          if (r_cnt == CNT_MAX) begin
            w_state_nxt = S_DEC;
            w_cnt_nxt   = CNT_MAX;
          end else begin
            w_state_nxt = S_KEY;
            w_cnt_nxt   = r_cnt + CNT_ONE;
          end
        end
        S_DEC: begin
          if (r_cnt == CNT_ZERO) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = CNT_ZERO;
            w_rdy_nxt   = 1'b1;
          end else begin
            w_state_nxt = S_DEC;
            w_cnt_nxt   = r_cnt - CNT_ONE;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = CNT_ZERO;
        end
      endcase
    end
  end

  // Output decode from registered state and counter only
  always_comb begin
    kex  = 1'b0;
    act  = 1'b0;
    rf   = 1'b0;
    k0   = 1'b0;
    case (r_state)
      S_KEY: begin
        kex = 1'b1;
        k0  = (r_cnt == CNT_ZERO);
      end
      S_DEC: begin
        act = 1'b1;
        rf  = (r_cnt == CNT_MAX);
      end
      default: begin
        kex = 1'b0;
        act = 1'b0;
      end
    endcase
    busy = kex | act;
    cnt  = r_cnt;
    rdy  = r_rdy;
  end

endmodule
